// File: rtl/game_logic_pkg.sv
// Shared constants for the game-rule stage: tile geometry, the fixed big-dot
// placement, state codes and pixel coordinate widths.
package game_logic_pkg;

  localparam int TILE_COLS  = 32;
  localparam int TILE_ROWS  = 24;
  localparam int TILE_SIZE  = 20;
  localparam int NUM_TILES  = TILE_COLS * TILE_ROWS;
  localparam int TILE_IDX_W = $clog2(NUM_TILES);

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int NUM_GHOSTS = 4;
  localparam int MAX_LIVES  = 7;
  localparam int unsigned EXTRA_LIFE_SCORE = 10000;

  typedef enum logic [2:0] {
    GAME_STATE_IDLE      = 3'd0,
    GAME_STATE_PLAYING   = 3'd1,
    GAME_STATE_DYING     = 3'd2,
    GAME_STATE_WIN       = 3'd3,
    GAME_STATE_GAME_OVER = 3'd4,
    GAME_STATE_LOAD      = 3'd5
  } game_state_t;

  // One-hot tilemap bit for (row, col).
  function automatic logic [NUM_TILES-1:0] tile_mask(input int row, input int col);
    return NUM_TILES'(1) << (row * TILE_COLS + col);
  endfunction

  // Big dots sit near the four corners of the maze.
  localparam logic [NUM_TILES-1:0] BIG_DOT_MASK =
      tile_mask(3, 1) | tile_mask(3, 30) | tile_mask(18, 1) | tile_mask(18, 30);

endpackage

// File: rtl/game_logic_collision_check.sv
// Player/ghost overlap test: both per-axis unsigned pixel distances must be
// strictly below DIST.
module game_logic_collision_check
  import game_logic_pkg::*;
#(
  parameter int unsigned DIST = 10
) (
  input  logic [X_W-1:0] player_x,
  input  logic [Y_W-1:0] player_y,
  input  logic [X_W-1:0] ghost_x,
  input  logic [Y_W-1:0] ghost_y,
  output logic           hit
);

  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;

  // Absolute differences on each axis, then the box compare.
  always_comb begin
    dx  = (player_x >= ghost_x) ? (player_x - ghost_x) : (ghost_x - player_x);
    dy  = (player_y >= ghost_y) ? (player_y - ghost_y) : (ghost_y - player_y);
    hit = (32'(dx) < DIST) && (32'(dy) < DIST);
  end

endmodule

// File: rtl/game_logic.sv
// Game-rule stage: owns the live dot/big-dot maps, score, lives, frightened
// mode and the game-state FSM. All state advances on the character tick.
// Optional build macro GAME_LOGIC_EXTRA_LIFE_EN awards one extra life the
// first time the score reaches 10000 in a game.
module game_logic
  import game_logic_pkg::*;
#(
  parameter int          SCORE_W        = 16,
  parameter int unsigned DOT_POINTS     = 10,
  parameter int unsigned BIG_DOT_POINTS = 50,
  parameter int unsigned GHOST_POINTS   = 200,
  parameter int unsigned START_LIVES    = 3,
  parameter int unsigned COLLIDE_DIST   = 10,
  parameter int unsigned FRIGHT_TICKS   = 40,
  parameter int unsigned DEATH_TICKS    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic [X_W-1:0]       player_x,
  input  logic [Y_W-1:0]       player_y,
  input  logic [X_W-1:0]       ghost1_x,
  input  logic [Y_W-1:0]       ghost1_y,
  input  logic [X_W-1:0]       ghost2_x,
  input  logic [Y_W-1:0]       ghost2_y,
  input  logic [X_W-1:0]       ghost3_x,
  input  logic [Y_W-1:0]       ghost3_y,
  input  logic [X_W-1:0]       ghost4_x,
  input  logic [Y_W-1:0]       ghost4_y,
  input  logic [NUM_TILES-1:0] tilemap_walls,
  output logic [NUM_TILES-1:0] tilemap_dots,
  output logic [NUM_TILES-1:0] tilemap_big_dots,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           lives,
  output logic [2:0]           game_state,
  output logic                 frightened,
  output logic [3:0]           ghost_eaten
);

  localparam int FRIGHT_W = $clog2(FRIGHT_TICKS + 1);
  localparam int DEATH_W  = $clog2(DEATH_TICKS + 1);

  game_state_t            state_reg;
  logic [NUM_TILES-1:0]   dots_reg;
  logic [NUM_TILES-1:0]   big_dots_reg;
  logic [SCORE_W-1:0]     score_reg;
  logic [2:0]             lives_reg;
  logic                   frightened_reg;
  logic [3:0]             ghost_eaten_reg;
  logic [FRIGHT_W-1:0]    fright_cnt_reg;
  logic [DEATH_W-1:0]     death_cnt_reg;
`ifdef GAME_LOGIC_EXTRA_LIFE_EN
  logic                   bonus_given_reg;
  logic                   award_life;
`endif

  assign tilemap_dots     = dots_reg;
  assign tilemap_big_dots = big_dots_reg;
  assign score            = score_reg;
  assign lives            = lives_reg;
  assign game_state       = state_reg;
  assign frightened       = frightened_reg;
  assign ghost_eaten      = ghost_eaten_reg;

  // Player tile from the sprite centre.
  logic [X_W:0]          center_x;
  logic [Y_W:0]          center_y;
  logic [X_W:0]          tile_col;
  logic [Y_W:0]          tile_row;
  logic                  tile_valid;
  logic [TILE_IDX_W-1:0] tile_idx;
  logic [NUM_TILES-1:0]  tile_bit;

  assign center_x   = {1'b0, player_x} + (X_W+1)'(TILE_SIZE / 2);
  assign center_y   = {1'b0, player_y} + (Y_W+1)'(TILE_SIZE / 2);
  assign tile_col   = center_x / (X_W+1)'(TILE_SIZE);
  assign tile_row   = center_y / (Y_W+1)'(TILE_SIZE);
  assign tile_valid = (tile_col < (X_W+1)'(TILE_COLS)) && (tile_row < (Y_W+1)'(TILE_ROWS));
  assign tile_idx   = TILE_IDX_W'(32'(tile_row) * TILE_COLS + 32'(tile_col));
  assign tile_bit   = tile_valid ? (NUM_TILES'(1) << tile_idx) : '0;

  // Four identical ghost overlap checks.
  logic [X_W-1:0] ghost_x [NUM_GHOSTS];
  logic [Y_W-1:0] ghost_y [NUM_GHOSTS];
  logic [3:0]     collide;

  assign ghost_x[0] = ghost1_x;
  assign ghost_y[0] = ghost1_y;
  assign ghost_x[1] = ghost2_x;
  assign ghost_y[1] = ghost2_y;
  assign ghost_x[2] = ghost3_x;
  assign ghost_y[2] = ghost3_y;
  assign ghost_x[3] = ghost4_x;
  assign ghost_y[3] = ghost4_y;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GHOSTS; gi++) begin : g_collide
      game_logic_collision_check #(
        .DIST(COLLIDE_DIST)
      ) u_check (
        .player_x (player_x),
        .player_y (player_y),
        .ghost_x  (ghost_x[gi]),
        .ghost_y  (ghost_y[gi]),
        .hit      (collide[gi])
      );
    end
  endgenerate

  // Tick outcome in PLAYING: eat first, then collisions with the post-eat
  // frightened state, then the win test on the post-eat maps.
  logic                 dot_hit;
  logic                 big_hit;
  logic                 fright_now;
  logic                 death;
  logic                 win;
  logic [3:0]           eaten_now;
  logic [NUM_TILES-1:0] dots_next;
  logic [NUM_TILES-1:0] big_dots_next;
  int unsigned          add_pts;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_next;
  logic [2:0]           lives_next;

  always_comb begin
    dot_hit       = |(dots_reg & tile_bit);
    big_hit       = |(big_dots_reg & tile_bit);
    dots_next     = dots_reg & ~tile_bit;
    big_dots_next = big_dots_reg & ~tile_bit;
    fright_now    = frightened_reg | big_hit;
    eaten_now     = fright_now ? collide : 4'b0000;
    death         = (|collide) && !fright_now;
    win           = (dots_next == '0) && (big_dots_next == '0);

    add_pts = 0;
    if (dot_hit) add_pts = add_pts + DOT_POINTS;
    if (big_hit) add_pts = add_pts + BIG_DOT_POINTS;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      if (eaten_now[i]) add_pts = add_pts + GHOST_POINTS;
    end
    score_sum  = (SCORE_W+1)'(score_reg) + (SCORE_W+1)'(add_pts);
    score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    lives_next = lives_reg;
    if (death && !win && (lives_reg != 3'd0)) lives_next = lives_reg - 3'd1;
`ifdef GAME_LOGIC_EXTRA_LIFE_EN
    award_life = !bonus_given_reg && (32'(score_reg) < EXTRA_LIFE_SCORE) &&
                 (32'(score_next) >= EXTRA_LIFE_SCORE);
    if (award_life && (lives_next != 3'(MAX_LIVES))) lives_next = lives_next + 3'd1;
`endif
  end

  // Game-state FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= GAME_STATE_IDLE;
      dots_reg        <= '0;
      big_dots_reg    <= '0;
      score_reg       <= '0;
      lives_reg       <= 3'd0;
      frightened_reg  <= 1'b0;
      ghost_eaten_reg <= 4'b0000;
      fright_cnt_reg  <= '0;
      death_cnt_reg   <= '0;
`ifdef GAME_LOGIC_EXTRA_LIFE_EN
      bonus_given_reg <= 1'b0;
`endif
    end else begin
      ghost_eaten_reg <= 4'b0000;
      case (state_reg)
        GAME_STATE_IDLE,
        GAME_STATE_WIN,
        GAME_STATE_GAME_OVER: begin
          if (start) state_reg <= GAME_STATE_LOAD;
        end
        GAME_STATE_LOAD: begin
          big_dots_reg   <= BIG_DOT_MASK & ~tilemap_walls;
          dots_reg       <= ~tilemap_walls & ~BIG_DOT_MASK;
          score_reg      <= '0;
          lives_reg      <= 3'(START_LIVES);
          frightened_reg <= 1'b0;
          fright_cnt_reg <= '0;
          death_cnt_reg  <= '0;
`ifdef GAME_LOGIC_EXTRA_LIFE_EN
          bonus_given_reg <= 1'b0;
`endif
          state_reg      <= GAME_STATE_PLAYING;
        end
        GAME_STATE_PLAYING: begin
          if (tick) begin
            dots_reg        <= dots_next;
            big_dots_reg    <= big_dots_next;
            score_reg       <= score_next;
            lives_reg       <= lives_next;
            ghost_eaten_reg <= eaten_now;
`ifdef GAME_LOGIC_EXTRA_LIFE_EN
            if (award_life) bonus_given_reg <= 1'b1;
`endif
            if (win) begin
              state_reg      <= GAME_STATE_WIN;
              frightened_reg <= 1'b0;
              fright_cnt_reg <= '0;
            end else if (death) begin
              state_reg      <= GAME_STATE_DYING;
              frightened_reg <= 1'b0;
              fright_cnt_reg <= '0;
              death_cnt_reg  <= '0;
            end else if (big_hit) begin
              frightened_reg <= 1'b1;
              fright_cnt_reg <= FRIGHT_W'(FRIGHT_TICKS);
            end else if (frightened_reg) begin
              fright_cnt_reg <= fright_cnt_reg - FRIGHT_W'(1);
              if (fright_cnt_reg == FRIGHT_W'(1)) frightened_reg <= 1'b0;
            end
          end
        end
        GAME_STATE_DYING: begin
          if (tick) begin
            if (death_cnt_reg == DEATH_W'(DEATH_TICKS - 1)) begin
              death_cnt_reg <= '0;
              state_reg     <= (lives_reg == 3'd0) ? GAME_STATE_GAME_OVER : GAME_STATE_PLAYING;
            end else begin
              death_cnt_reg <= death_cnt_reg + DEATH_W'(1);
            end
          end
        end
        default: state_reg <= GAME_STATE_IDLE;
      endcase
    end
  end

endmodule

// File: doc/game_logic.md
Name: game_logic

Overview:
- Game-rule stage between the character controllers and the renderer.
- Consumes player and ghost pixel positions plus the wall tilemap.
- Owns the live dot and big-dot tilemaps, score, lives, frightened mode and the game-state FSM.
- Its outputs feed the renderer and the player controller; all updates are qualified by the character-update tick.

Parameters:
- TILE_COLS, 32, tiles per row
- TILE_ROWS, 24, tile rows
- TILE_SIZE, 20, pixels per tile edge
- SCORE_W, 16, score width
- DOT_POINTS, 10, points per dot
- BIG_DOT_POINTS, 50, points per big dot
- GHOST_POINTS, 200, points per eaten ghost
- START_LIVES, 3, lives loaded at game start
- COLLIDE_DIST, 10, pixel distance below which player and ghost collide (per axis)
- FRIGHT_TICKS, 40, frightened duration in ticks
- DEATH_TICKS, 10, DYING pause length in ticks

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle character-update strobe, clk domain
- start  in  1  level; begins or restarts a game from IDLE, WIN or GAME_OVER
- player_x  in  10  player top-left pixel x
- player_y  in  9  player top-left pixel y
- ghostN_x / ghostN_y  in  10 / 9  ghost N (1..4) top-left pixel
- tilemap_walls  in  TILE_ROWS*TILE_COLS  wall map; bit row*TILE_COLS+col
- tilemap_dots  out  TILE_ROWS*TILE_COLS  remaining small dots, same indexing
- tilemap_big_dots  out  TILE_ROWS*TILE_COLS  remaining big dots
- score  out  SCORE_W  current score
- lives  out  3  remaining lives
- game_state  out  3  GAME_STATE_* code
- frightened  out  1  high while ghosts are edible
- ghost_eaten  out  4  one-cycle pulse per ghost eaten; resets that ghost's controller

Behaviour:
- All outputs are registered. On reset:
  - dots = 0, big_dots = 0, score = 0, lives = 0
  - game_state = IDLE, frightened = 0, ghost_eaten = 0
- Player tile: col = (player_x + TILE_SIZE/2) / TILE_SIZE, row = (player_y + TILE_SIZE/2) / TILE_SIZE. Constant division, combinational. Out-of-range row/col (≥ limit) means no eat.
- IDLE --start--> LOAD:
  - takes one cycle
  - big_dots = BIG_DOT_MASK & ~walls
  - dots = ~walls & ~BIG_DOT_MASK
  - score = 0, lives = START_LIVES
  - then PLAYING
- PLAYING: on tick only, evaluated in this order within one cycle:
  - Eat:
    - dot bit set at player tile → clear it, score += DOT_POINTS
    - big-dot bit set → clear it, score += BIG_DOT_POINTS, frightened = 1, fright counter = FRIGHT_TICKS (re-arms if already frightened)
  - Collision per ghost: |px-gx| < COLLIDE_DIST and |py-gy| < COLLIDE_DIST, unsigned differences.
    - frightened: score += GHOST_POINTS per colliding ghost, pulse ghost_eaten[N]
    - otherwise → DYING, lives -= 1, frightened cleared
  - Win: if the post-eat dot and big-dot maps are both all-zero → WIN. Win has priority over a same-tick death.
  - Fright counter decrements each tick; frightened drops on the tick it reaches 0.
- DYING:
  - counts DEATH_TICKS ticks
  - lives == 0 → GAME_OVER, else PLAYING
  - tilemaps and score are retained
- WIN / GAME_OVER --start--> LOAD (new game).
- start is ignored in PLAYING and DYING.
- Score saturates at 2^SCORE_W-1, never wraps. Multiple additions in one tick are summed, then saturated.
- Cycle timing: effects are visible on outputs the cycle after the tick cycle. ghost_eaten is high exactly one clk cycle.
- Reset mid-game returns to IDLE with cleared maps on the next edge.

Optional Feature:
- Macro: GAME_LOGIC_EXTRA_LIFE_EN
- When defined:
  - the first time score crosses from < 10000 to ≥ 10000, lives += 1 (saturating at 7)
  - a one-shot flag blocks further awards until LOAD
- When undefined: lives only decrease; no flag register exists.

Decomposition:
- Shared package/define file holds:
  - GAME_STATE_IDLE=0, PLAYING=1, DYING=2, WIN=3, GAME_OVER=4, LOAD=5
  - BIG_DOT_MASK (tiles (3,1), (3,30), (18,1), (18,30))
  - tile geometry constants
- One sub-module: collision_check. Per-ghost absolute-difference compare, instantiated 4×.

Test Plan:
- Reset, then start with all-zero walls → next cycle LOAD, then PLAYING. Dots = all ones minus 4 big-dot bits; lives=3; score=0.
- Player at (20,20), tick → dot bit 33 cleared, score=10. Same position, second tick → score stays 10.
- Player on tile (3,1), tick → big bit 97 cleared, score=50, frightened=1. After 40 more ticks → frightened=0.
- Frightened, ghost2 at player_x+5 → score +=200, ghost_eaten=4'b0010 for one cycle. Not frightened → DYING, lives=2; after 10 ticks → PLAYING.
- lives=1, collision → DYING; after 10 ticks → GAME_OVER. start → LOAD, lives=3, score=0.
- Single remaining dot eaten on the same tick as a ghost collision → WIN, lives unchanged. Score preset near max + 50 → saturates at 65535.
